// File: rtl/tbird_pkg.sv
// Shared types and constants for the T-bird lamp decoder.
// Holds the level type, per-side state enum, error codes, lamp patterns and
// the level transition rule used by each side decoder.
package tbird_pkg;

  typedef logic [1:0] level_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } side_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_PAT   = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;
  localparam logic [1:0] ERR_BOTH  = 2'b11;

  // Lamp patterns {outer,middle,inner} for levels 0..3
  localparam logic [2:0] PAT_L0 = 3'b000;
  localparam logic [2:0] PAT_L1 = 3'b001;
  localparam logic [2:0] PAT_L2 = 3'b011;
  localparam logic [2:0] PAT_L3 = 3'b111;

  // A sweep may rest at 0, climb one level at a time, and fall from 3 to 0
  function automatic logic legal_step(level_t cur, level_t nxt);
    if (nxt == 2'd0) return (cur == 2'd0) || (cur == 2'd3);
    return (cur != 2'd3) && (nxt == level_t'(cur + 2'd1));
  endfunction

endpackage

// File: rtl/tbird_side_decoder.sv
// One side of the T-bird lamp decoder: pattern decode, IDLE/RUN FSM,
// transition check and optional completed-sweep counter.
// Ports: clk, reset (sync, active-high), step (sample strobe), lamp {a,b,c};
//   level/cnt are registered; run_nxt_c, pat_err_c, trans_err_c are the
//   combinational next-RUN and per-step error flags used by the top level.
// Macro TBIRD_DEC_CNT_EN: when defined the sweep counter is built,
//   otherwise cnt is tied to zero.
module tbird_side_decoder
  import tbird_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [2:0]       lamp,
  output level_t           level,
  output logic [CNT_W-1:0] cnt,
  output logic             run_nxt_c,
  output logic             pat_err_c,
  output logic             trans_err_c
);

  side_state_e state, state_nxt;
  level_t      level_nxt;
  level_t      dec;
  logic        pat_ok;

  // Lamp pattern decode
  always_comb begin
    pat_ok = 1'b1;
    dec    = 2'd0;
    case (lamp)
      PAT_L0:  dec = 2'd0;
      PAT_L1:  dec = 2'd1;
      PAT_L2:  dec = 2'd2;
      PAT_L3:  dec = 2'd3;
      default: pat_ok = 1'b0;
    endcase
  end

  // State and level register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      level <= 2'd0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  // Next state; an illegal transition still resyncs to the new level,
  // an illegal pattern keeps the level but drops back to IDLE
  always_comb begin
    state_nxt   = state;
    level_nxt   = level;
    pat_err_c   = 1'b0;
    trans_err_c = 1'b0;
    if (step) begin
      if (!pat_ok) begin
        pat_err_c = 1'b1;
        state_nxt = IDLE;
      end else begin
        trans_err_c = !legal_step(level, dec);
        level_nxt   = dec;
        state_nxt   = (dec != 2'd0) ? RUN : IDLE;
      end
    end
  end

  assign run_nxt_c = (state_nxt == RUN);

`ifdef TBIRD_DEC_CNT_EN
  logic sweep_done;

  assign sweep_done = step && pat_ok && (level == 2'd3) && (dec == 2'd0);

  // Saturating completed-sweep counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (sweep_done && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/tbird_lamp_decoder.sv
// T-bird tail-lamp decoder top: two side decoders plus direction output and
// sticky error arbitration.
// Ports: clk, reset (sync, active-high), step, lamp_l/lamp_r {a,b,c},
//   clr_err; outputs level_l/level_r, dir_valid, dir (1 = right), err,
//   err_code, cnt_l/cnt_r (all registered).
// Macro TBIRD_DEC_CNT_EN: enables the per-side sweep counters.
module tbird_lamp_decoder
  import tbird_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [2:0]       lamp_l,
  input  logic [2:0]       lamp_r,
  input  logic             clr_err,
  output logic [1:0]       level_l,
  output logic [1:0]       level_r,
  output logic             dir_valid,
  output logic             dir,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_r
);

  logic       run_nxt_l, run_nxt_r;
  logic       pat_l, pat_r, trans_l, trans_r;
  logic [1:0] new_code_c;

  tbird_side_decoder #(.CNT_W(CNT_W)) u_left (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .lamp        (lamp_l),
    .level       (level_l),
    .cnt         (cnt_l),
    .run_nxt_c   (run_nxt_l),
    .pat_err_c   (pat_l),
    .trans_err_c (trans_l)
  );

  tbird_side_decoder #(.CNT_W(CNT_W)) u_right (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .lamp        (lamp_r),
    .level       (level_r),
    .cnt         (cnt_r),
    .run_nxt_c   (run_nxt_r),
    .pat_err_c   (pat_r),
    .trans_err_c (trans_r)
  );

  // Error priority for this step: both-running > transition > pattern
  always_comb begin
    new_code_c = ERR_NONE;
    if (step && run_nxt_l && run_nxt_r) new_code_c = ERR_BOTH;
    else if (trans_l || trans_r)        new_code_c = ERR_TRANS;
    else if (pat_l || pat_r)            new_code_c = ERR_PAT;
  end

  // Direction and sticky error; a fresh error beats a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_valid <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (step) begin
        dir_valid <= run_nxt_l ^ run_nxt_r;
        dir       <= run_nxt_r & ~run_nxt_l;
      end
      if (new_code_c != ERR_NONE) begin
        if (!err || clr_err) begin
          err      <= 1'b1;
          err_code <= new_code_c;
        end
      end else if (clr_err) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: doc/tbird_lamp_decoder.md
TBIRD_LAMP_DECODER -- requirements
Module: tbird_lamp_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of each completed-sweep counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port step, input, 1 bit: lamp-sample strobe, high for one clk per lamp-sequencer step.
REQ-005 SHALL have port lamp_l, input, 3 bits: left lamps {a,b,c} = {outer,middle,inner}.
REQ-006 SHALL have port lamp_r, input, 3 bits: right lamps {a,b,c}, same ordering as lamp_l.
REQ-007 SHALL have port clr_err, input, 1 bit: clears the sticky error.
REQ-008 SHALL have port level_l, output, 2 bits: decoded left lamp level, 0 to 3.
REQ-009 SHALL have port level_r, output, 2 bits: decoded right lamp level, 0 to 3.
REQ-010 SHALL have port dir_valid, output, 1 bit: exactly one side is sweeping.
REQ-011 SHALL have port dir, output, 1 bit: 0 = left, 1 = right; meaningful only while dir_valid = 1.
REQ-012 SHALL have port err, output, 1 bit: sticky error flag.
REQ-013 SHALL have port err_code, output, 2 bits: 01 = illegal pattern, 10 = illegal transition, 11 = both sides sweeping.
REQ-014 SHALL have ports cnt_l and cnt_r, outputs, CNT_W bits each: completed sweeps per side, saturating.

Function
REQ-015 SHALL sample lamps only on cycles with step = 1; with step = 0, all state SHALL hold.
REQ-016 SHALL decode {a,b,c} as 000->0, 001->1, 011->2, 111->3; all other patterns are illegal.
REQ-017 SHALL register all outputs, updated on the clk edge that samples step = 1 (latency 1 cycle).
REQ-018 Per-side FSM states SHALL be IDLE (level 0) and RUN (level 1..3).
REQ-019 Legal per-step transitions SHALL be 0->0, 0->1, 1->2, 2->3 and 3->0; k->k for k > 0 is illegal.
REQ-020 On a legal step, the side SHALL take the new level and enter RUN if level != 0, otherwise IDLE.
REQ-021 On an illegal transition, the side SHALL raise code 10 and still take the new level and state (resync).
REQ-022 On an illegal pattern, the side SHALL raise code 01, keep level unchanged, and force IDLE.
REQ-023 Each 3->0 transition SHALL increment that side's counter, holding at 2^CNT_W-1.
REQ-024 dir_valid SHALL be 1 exactly when one side is in RUN; dir SHALL identify that side.
REQ-025 If both sides are in RUN after a step, the block SHALL raise code 11 and set dir_valid = 0.
REQ-026 err_code SHALL latch the first error and hold until clr_err.
   - Simultaneous errors in one step: priority 11 > 10 > 01.
   - Left and right errors of equal code in one step: report that code once.
REQ-027 clr_err SHALL clear err and err_code next cycle.
   - If an error is detected in the same cycle as clr_err, the new error SHALL win: err = 1 with the new code.
REQ-028 clr_err SHALL NOT affect levels, FSM states or counters.

Reset
REQ-029 On reset = 1 at a clk edge, the block SHALL set:
   - level_l = level_r = 0 and both FSMs to IDLE;
   - dir_valid = 0 and dir = 0;
   - err = 0 and err_code = 00;
   - cnt_l = cnt_r = 0.
REQ-030 Reset SHALL take priority over step and clr_err; reset mid-sweep SHALL discard the sweep without counting it.
REQ-031 On the first step after reset, any nonzero legal level other than 1 SHALL be flagged as an illegal transition.

Configuration
REQ-032 Macro TBIRD_DEC_CNT_EN defined: the counters SHALL be present and behave per REQ-023.
REQ-033 Macro TBIRD_DEC_CNT_EN undefined: cnt_l and cnt_r SHALL be tied to 0 and no counter flops SHALL be generated; all other behaviour is unchanged.

Structure
REQ-034 A shared package tbird_pkg SHALL hold:
   - the 2-bit level type;
   - the side-state enum (IDLE, RUN);
   - the err_code constants (ERR_NONE, ERR_PAT, ERR_TRANS, ERR_BOTH);
   - the lamp pattern constants (000, 001, 011, 111).
REQ-035 Per-side logic SHALL live in sub-module tbird_side_decoder, instantiated twice. It covers:
   - pattern decode;
   - the FSM;
   - transition check;
   - the counter.
REQ-036 The top level SHALL hold only direction logic and error arbitration/latching.

Verification
REQ-037 Right sweep, lamp_r = 001, 011, 111, 000 on four steps -> level_r = 1, 2, 3, 0; cnt_r = 1; dir_valid = 1 and dir = 1 for the first three steps; err = 0.
REQ-038 lamp_l = 101 on one step -> err = 1, err_code = 01, level_l unchanged, left FSM IDLE.
REQ-039 lamp_l = 001 then 111 -> err_code = 10, level_l = 3; a following 000 then increments cnt_l to 1.
REQ-040 lamp_l = 001 and lamp_r = 001 on the same step -> err_code = 11, dir_valid = 0.
REQ-041 Raise err, then pulse clr_err with no step -> err = 0 and err_code = 00 next cycle. Repeat with clr_err coincident with an illegal-pattern step -> err = 1, err_code = 01.
REQ-042 With CNT_W = 2, run 5 full right sweeps -> cnt_r = 3. Assert reset mid-sweep (level_r = 2) -> all outputs at reset values. Build without TBIRD_DEC_CNT_EN -> cnt_r = 0 throughout.
